reaction_timer_core: RTL

Upstream stage of the 7-segment display path. Synchronizes the player's push-button, generates a pseudo-random start delay, lights the "go" LED, then measures reaction time in milliseconds. Produces the 14-bit BCD-convertible `value` (0–9999) and the `show_error` flag that the display driver consumes directly. False starts are flagged for display as "Err".

---
 rtl/reaction_timer_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/reaction_timer_core.sv
// Reaction-timer front end: button synchronizer, ms prescaler, LFSR start delay,
// round FSM and the registered value/show_error/led_go outputs for the display path.
module reaction_timer_core #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  output logic        led_go,
  output logic [13:0] value,
  output logic        show_error,
  output logic [2:0]  state
);

  localparam int              PW         = $clog2(TICKS_PER_MS);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [13:0]     VALUE_MAX  = 14'(MAX_MS);
  localparam logic [11:0]     DELAY_BASE = 12'(MIN_DELAY_MS);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FALSE  = 3'd4
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches all-zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic          press_q, press_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   down_q, down_d;
  logic [15:0]   lfsr_q, lfsr_d;
  state_e        state_q, state_d;
  logic [13:0]   value_q, value_d;
  logic          show_error_q, show_error_d;
  logic          led_go_q, led_go_d;
  logic          tick;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    press_d  = sync2_q & ~sync3_q;
    lfsr_d   = lfsr_step(lfsr_q);
    tick     = (presc_q == PRESC_LAST);
    state_d  = state_q;
    value_d  = value_q;
    down_d   = down_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (press_q) begin
          state_d = S_WAIT;
          value_d = 14'd0;
          down_d  = DELAY_BASE + {1'b0, lfsr_q[10:0]};
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        // Press beats a coincident final tick, turning it into a false start.
        if (press_q) begin
          state_d = S_FALSE;
          value_d = 14'd0;
        end else if (tick) begin
          if (down_q <= 12'd1) begin
            state_d = S_TIMING;
            value_d = 14'd0;
          end else begin
            down_d = down_q - 12'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_TIMING: begin
        if (press_q) begin
          state_d = S_DONE;
        end else if (tick && (value_q < VALUE_MAX)) begin
          value_d = value_q + 14'd1;
        end else begin
          value_d = value_q;
        end
      end
      S_FALSE: begin
        value_d = 14'd0;
        if (press_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_d != state_q) || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    led_go_d     = (state_d == S_TIMING);
    show_error_d = (state_d == S_FALSE);
  end

  // All state and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      press_q      <= 1'b0;
      presc_q      <= '0;
      down_q       <= 12'd0;
      lfsr_q       <= LFSR_SEED;
      state_q      <= S_IDLE;
      value_q      <= 14'd0;
      show_error_q <= 1'b0;
      led_go_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      press_q      <= press_d;
      presc_q      <= presc_d;
      down_q       <= down_d;
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      value_q      <= value_d;
      show_error_q <= show_error_d;
      led_go_q     <= led_go_d;
    end
  end

  assign led_go     = led_go_q;
  assign value      = value_q;
  assign show_error = show_error_q;
  assign state      = state_q;

endmodule
